// File: rtl/inv_chain_pipe.sv
// Registered DEPTH-stage pass/invert chain with a synchronous ring-oscillator mode.
// Latency: DEPTH-1 cycles from input accept to out_valid; 1 word/cycle throughput.
// Backpressure: whole chain stalls when out_valid & !out_ready; in_ready drops with it.
module inv_chain_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             ring_out,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [1:0] M_BUF  = 2'b00;
    localparam logic [1:0] M_INV  = 2'b01;
    localparam logic [1:0] M_LAST = 2'b10;
    localparam logic [1:0] M_RING = 2'b11;

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [WIDTH-1:0] dat     [DEPTH];
    logic [WIDTH-1:0] dat_nxt [DEPTH];
    logic [1:0]       active_mode;
    logic [1:0]       eff_mode;
    logic [CW-1:0]    cnt;
    logic             ring_q;
    logic             adv;
    logic             fire;

    function automatic logic [WIDTH-1:0] stage_op(input logic [1:0] m, input logic last,
                                                  input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = x;
        case (m)
            M_INV:   r = ~x;
            M_LAST:  r = last ? ~x : x;
            default: r = x;
        endcase
        return r;
    endfunction

    assign busy      = |vld;
    // Mode is frozen while words are in flight so each word finishes under its entry mode.
    assign eff_mode  = busy ? active_mode : mode;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && (eff_mode != M_RING);
    assign fire      = in_valid && in_ready;
    assign ring_out  = ring_q;

    always_comb begin
        vld_nxt = vld;
        for (int k = 0; k < DEPTH; k++) begin
            dat_nxt[k] = dat[k];
        end
        if (adv) begin
            vld_nxt[0] = fire;
            dat_nxt[0] = fire ? stage_op(eff_mode, DEPTH == 1, in_data) : '0;
            // Bubbles shift as zeros so an invalid stage never carries stale or inverted data.
            for (int k = 1; k < DEPTH; k++) begin
                vld_nxt[k] = vld[k-1];
                dat_nxt[k] = vld[k-1] ? stage_op(eff_mode, k == DEPTH - 1, dat[k-1]) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat[k] <= '0;
            end
        end else begin
            vld <= vld_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                dat[k] <= dat_nxt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_mode <= M_BUF;
        end else if (!busy) begin
            active_mode <= mode;
        end
    end

    // Half-period of DEPTH clocks mimics an odd-length inverter ring.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            ring_q <= 1'b0;
        end else if (eff_mode == M_RING) begin
            if (cnt == CW'(DEPTH - 1)) begin
                cnt    <= '0;
                ring_q <= ~ring_q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt    <= '0;
            ring_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inv_chain_pipe.sv
// Directed bench for inv_chain_pipe: scoreboard on the DEPTH=5 and DEPTH=4 instances.
module tb_inv_chain_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       ring_out;
    logic       busy;

    logic       en4;
    logic       in_valid4;
    logic [1:0] mode4 = 2'b01;
    logic       out_ready4 = 1'b1;
    logic       in_ready4;
    logic       out_valid4;
    logic [7:0] out_data4;
    logic       ring_out4;
    logic       busy4;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_mode;
    logic [7:0] q5[$];
    logic [7:0] q4[$];

    assign in_valid4 = in_valid & en4;

    always #5 clk = ~clk;

    inv_chain_pipe #(.WIDTH(8), .DEPTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .ring_out(ring_out), .busy(busy)
    );

    inv_chain_pipe #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4),
        .in_valid(in_valid4), .in_data(in_data), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready4),
        .ring_out(ring_out4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_of(input logic [7:0] x, input logic [1:0] m, input int depth);
        case (m)
            2'b01:   return (depth % 2 == 1) ? ~x : x;
            2'b10:   return ~x;
            default: return x;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expectations pushed on input handshake, popped on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            q5.delete();
            q4.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb5_pending", q5.size() > 0, 1);
                if (q5.size() > 0) chk("sb5_data", out_data, q5.pop_front());
            end
            if (in_valid && in_ready) q5.push_back(exp_of(in_data, exp_mode, 5));
            if (out_valid4) begin
                chk("sb4_pending", q4.size() > 0, 1);
                if (q4.size() > 0) chk("sb4_data", out_data4, q4.pop_front());
            end
            if (in_valid4 && in_ready4) q4.push_back(exp_of(in_data, 2'b01, 4));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w [4];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;

        // Reset state
        rst_n = 1'b0; mode = 2'b00; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b1; en4 = 1'b0; exp_mode = 2'b00;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ring_out", ring_out, 0);

        // Buffer mode single word, latency check
        tick();
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("lat_out_valid", out_valid, (c == 4) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        chk("buf_busy_after", busy, 0);

        // Invert-every-stage stream on both depths
        tick();
        mode = 2'b01; exp_mode = 2'b01; en4 = 1'b1;
        in_valid = 1'b1; in_data = 8'hA5; tick();
        in_data = 8'h0F; tick();
        in_data = 8'hFF; tick();
        in_valid = 1'b0; en4 = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("inv_q5_empty", q5.size(), 0);
        chk("inv_q4_empty", q4.size(), 0);

        // Invert-last-stage with a 3-cycle output stall
        tick();
        mode = 2'b10; exp_mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = w[i];
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, 8'hEE);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("stall_q5_empty", q5.size(), 0);

        // Ring mode
        tick();
        mode = 2'b11;
        for (int j = 0; j < 46; j++) begin
            tick();
            @(negedge clk);
            chk("ring_out", ring_out, ((j + 1) / 5) % 2);
            chk("ring_in_ready", in_ready, 0);
            chk("ring_out_valid", out_valid, 0);
        end
        tick();
        mode = 2'b00;
        tick();
        @(negedge clk);
        chk("ring_exit_out", ring_out, 0);
        chk("ring_exit_in_ready", in_ready, 1);

        // Mode change while busy only applies after drain
        tick();
        exp_mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = w[i] ^ 8'h0C;
            tick();
        end
        in_valid = 1'b0; mode = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            tick();
        end
        chk("drain_busy", busy, 0);
        tick();
        exp_mode = 2'b01;
        in_valid = 1'b1; in_data = 8'h96;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("modechg_q5_empty", q5.size(), 0);

        // Mid-stream reset discards in-flight words
        tick();
        mode = 2'b00; exp_mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = w[i] + 8'h70;
            tick();
        end
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_out_data", out_data, 0);
        repeat (10) tick();
        @(negedge clk);
        chk("mrst_no_stale_busy", busy, 0);
        chk("mrst_q5_empty", q5.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inv_chain_pipe.md
Name: inv_chain_pipe

Overview:
- Parametrised, clocked successor to the single inverter, non-inverting buffer and 5-stage inverter ring blocks.
- Moves a WIDTH-bit word through a DEPTH-stage registered chain with valid/ready handshake on both sides.
- Each stage either passes or inverts the word according to a run-time mode.
- A ring mode emulates an odd-length inverter ring oscillator synchronously: a toggling output with a period of 2*DEPTH clocks.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 5, number of register stages in the chain (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- mode  input  2  00 buffer, 01 invert-every-stage, 10 invert-last-stage, 11 ring
- in_valid  input  1  upstream word valid
- in_data  input  WIDTH  upstream word
- in_ready  output  1  chain can accept a word this cycle
- out_valid  output  1  last stage holds a valid word
- out_data  output  WIDTH  last-stage word
- out_ready  input  1  downstream accepts the word
- ring_out  output  1  ring-mode oscillator output
- busy  output  1  at least one stage holds a valid word

Behaviour:
- Reset (rst_n=0 at a rising edge): all stage valid bits and data, active_mode, ring counter and ring_out go to 0. in_ready=1 (when mode!=11), out_valid=0, out_data=0, busy=0.
- Reset asserted mid-stream discards in-flight words. No output beat completes on the reset cycle.
- eff_mode = busy ? active_mode : mode. active_mode <= mode on every cycle with busy=0; it is held while busy=1.
- A mode change while busy takes effect only after the chain drains. Words already in flight always complete under the mode they entered with.
- Advance condition: adv = !out_valid | out_ready.
  - When adv=1, every stage shifts one place. Stage 0 loads in_data/in_valid when the input handshake fires; otherwise it loads a bubble (valid=0, data=0).
  - When adv=0, the whole chain holds.
  - Bubbles are not collapsed.
- in_ready = adv & (eff_mode != 11). The input handshake fires on in_valid & in_ready.
- Stage operation, applied when a word moves into stage k (k = 0..DEPTH-1):
  - 00: pass.
  - 01: bitwise invert at every stage, so out_data = in_data if DEPTH is even and ~in_data if DEPTH is odd.
  - 10: invert only at stage DEPTH-1, so out_data = ~in_data.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1 (visible in cycle N+DEPTH-1 to N+DEPTH), with no stalls. Throughput is 1 word/cycle.
- out_valid/out_data are held stable while out_valid=1 and out_ready=0.
- Invalid stages carry data 0, so out_data=0 whenever out_valid=0.
- busy = OR of all stage valid bits.
- Ring mode (eff_mode=11, only reachable with busy=0):
  - in_ready=0 and out_valid=0.
  - A counter cnt (clog2(DEPTH)+1 bits) counts 0..DEPTH-1. On the edge where cnt=DEPTH-1, cnt wraps to 0 and ring_out toggles.
  - ring_out is therefore high for DEPTH cycles and low for DEPTH cycles; first toggle is DEPTH edges after entry.
- Leaving ring mode (eff_mode!=11): cnt and ring_out clear to 0 on the next edge.
- ring_out=0 in all non-ring modes.
- Simultaneous input accept and output accept in the same cycle is legal and sustains full throughput.

Test Plan:
- Reset, DEPTH=5, WIDTH=8, mode=00: send 0x3C at edge 0 with out_ready=1 -> out_valid=1 with out_data=0x3C after edge 4 for one cycle; busy=0 afterwards.
- mode=01, DEPTH=5: stream 0xA5, 0x0F, 0xFF on consecutive cycles -> outputs 0x5A, 0xF0, 0x00 on consecutive cycles. Repeat with DEPTH=4 -> 0xA5, 0x0F, 0xFF unchanged.
- mode=10: back-to-back words, then out_ready=0 for 3 cycles while the first output is valid -> in_ready=0 and out_data frozen at ~word for the stall. No word is lost or duplicated; order is preserved on release.
- mode=11, DEPTH=5, 40 cycles -> in_ready=0, out_valid=0, ring_out toggles every 5 edges (period 10). Switch mode to 00 -> ring_out=0 on the next edge and in_ready=1.
- mode=00 with 3 words in flight, then mode changed to 01 -> in-flight words exit unchanged. A word sent after busy=0 exits under the new mode (inverted for DEPTH=5).
- Mid-stream rst_n=0 for 1 cycle with 4 words in flight -> out_valid=0, busy=0, out_data=0 the next cycle, and no stale word ever appears.
